// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU driver: op codes, legality check, FSM encoding.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SRA = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Codes 110 and 111 have no ALU function behind them.
   function automatic logic is_legal_op(input logic [2:0] op);
      logic legal;
      case (op)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SRL, ALU_SRA: legal = 1'b1;
         default:                                             legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_iter_driver.sv
// Sequential front-end for the combinational ALU: applies acc = acc op B a given
// number of times and returns the final accumulator over a valid/ready response.
module alu_iter_driver
   import alu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [2:0]       req_op,
   input  logic [CNT_W-1:0] req_cnt,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_op,
   input  logic [31:0]      alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_err
);

   localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [31:0]      acc_r;
   logic [31:0]      b_r;
   logic [2:0]       op_r;
   logic [CNT_W-1:0] rem_r;
   logic [31:0]      rsp_data_r;
   logic             rsp_err_r;
   logic             accept_s;
   logic             legal_s;

   assign accept_s = req_valid && (state_r == IDLE);
   assign legal_s  = is_legal_op(req_op);
   assign rsp_data = rsp_data_r;
   assign rsp_err  = rsp_err_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decision; illegal ops and zero counts skip RUN entirely.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (!legal_s || (req_cnt == '0)) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (rem_r == REM_ONE) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake flags and ALU drive; the ALU inputs stay at zero outside RUN.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alu_a     = 32'h0000_0000;
      alu_b     = 32'h0000_0000;
      alu_op    = 3'b000;
      case (state_r)
         IDLE: req_ready = 1'b1;
         RUN: begin
            alu_a  = acc_r;
            alu_b  = b_r;
            alu_op = op_r;
         end
         DONE:    rsp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Command latch, accumulator/counter update and response capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r      <= 32'h0000_0000;
         b_r        <= 32'h0000_0000;
         op_r       <= 3'b000;
         rem_r      <= '0;
         rsp_data_r <= 32'h0000_0000;
         rsp_err_r  <= 1'b0;
      end else if (accept_s) begin
         acc_r      <= req_a;
         b_r        <= req_b;
         op_r       <= req_op;
         rem_r      <= req_cnt;
         rsp_err_r  <= !legal_s;
         rsp_data_r <= (legal_s && (req_cnt == '0)) ? req_a : 32'h0000_0000;
      end else if (state_r == RUN) begin
         acc_r <= alu_c;
         rem_r <= rem_r - REM_ONE;
         if (rem_r == REM_ONE) begin
            rsp_data_r <= alu_c;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: doc/alu_iter_driver.md
Name: alu_iter_driver

Overview:
- Sequential front-end for the team's combinational 32-bit ALU (ops: add, sub, and, or, srl, sra).
- Accepts one command over a valid/ready handshake: operands A and B, an op, and a repeat count N.
- Drives the external ALU inputs each cycle, feeding the result back as A N times (acc = acc op B), then returns the final value over a valid/ready response handshake.
- Sits between the datapath control and the ALU instance. Enables multi-step operations such as repeated add and multi-step shift.

Parameters:
- CNT_W, 8: width of the repeat-count field.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  command valid.
- req_ready  output  1  command accepted when high with req_valid.
- req_a  input  32  initial accumulator value.
- req_b  input  32  fixed second operand.
- req_op  input  3  ALU op code.
- req_cnt  input  CNT_W  number of ALU iterations N.
- alu_a  output  32  to ALU input A.
- alu_b  output  32  to ALU input B.
- alu_op  output  3  to ALU op select.
- alu_c  input  32  ALU result (combinational, same cycle).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when high with rsp_valid.
- rsp_data  output  32  final accumulator.
- rsp_err  output  1  illegal op flag.

Behaviour:
- Decided: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0, all internal registers 0.
- req_ready is high only in IDLE (combinational from state). There is no accept while in RUN or DONE.
- Accept happens at an edge with req_valid && req_ready. At that edge the block latches acc<=req_a, b_reg<=req_b, op_reg<=req_op, rem<=req_cnt. Next state:
  - req_op is 110 or 111 (illegal): DONE with err=1, rsp_data=0. No ALU cycles.
  - req_cnt==0: DONE with rsp_data=req_a and err=0.
  - otherwise: RUN.
- RUN, every cycle:
  - Outputs are alu_a=acc, alu_b=b_reg, alu_op=op_reg.
  - At the edge: acc<=alu_c and rem<=rem-1.
  - When rem==1 at the edge, go to DONE with rsp_data<=alu_c.
- alu_a, alu_b and alu_op are 0 outside RUN, so the ALU sees no spurious activity.
- Latency: rsp_valid rises max(N,1) cycles after the accept edge. An illegal op always takes 1 cycle.
- DONE: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready. On the handshake edge go to IDLE; rsp_valid falls next cycle and req_ready rises.
- Arithmetic is 32-bit wrap-around, as the ALU defines it. The block does no saturation and has no overflow flag. The shift amount is the full b_reg value as passed to the ALU.
- req_* inputs are ignored outside IDLE. Their changes during RUN have no effect.
- rst_n low at any time, including mid-RUN or in DONE, forces IDLE and the reset values immediately. The in-flight command is discarded and no response is produced.
- Max N = 2^CNT_W-1. The counter never wraps because RUN exits at rem==1.

Decomposition:
- Shared package alu_pkg:
  - op-code constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SRL=100, ALU_SRA=101;
  - an is_legal_op function;
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- No sub-module. The counter and accumulator stay inline.
- The existing ALU is instantiated alongside this block at the next level up, and in the bench.

Test Plan:
- Repeated add: a=0, b=5, op=000, N=4 -> rsp_data=0x14 and rsp_err=0. rsp_valid rises 4 cycles after accept, with alu_op=000 during exactly 4 cycles.
- Repeated sra: a=0x80000000, b=1, op=101, N=3 -> rsp_data=0xF0000000. Repeated srl: a=0xF0, b=4, op=100, N=2 -> rsp_data=0x0.
- N=0: a=0x1234, op=001 -> rsp_data=0x1234, rsp_valid 1 cycle after accept, alu_a/alu_b/alu_op held at 0 throughout.
- Illegal op: op=110, N=5 -> rsp_err=1 and rsp_data=0 after 1 cycle, with no ALU cycles.
- Backpressure: complete a=7, b=1, op=000, N=1, hold rsp_ready=0 for 3 cycles -> rsp_valid=1, rsp_data=8 and req_ready=0 stable. A second req_valid meanwhile is not accepted. After the handshake edge, req_ready=1 the next cycle.
- Reset mid-run: N=200, pull rst_n low 10 cycles after accept (asynchronous, between edges) -> rsp_valid=0, req_ready=1 and alu_*=0 immediately. No response ever appears after release, and a fresh command then completes normally.
